// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the fetch stage: data/address widths, the NOP
//   encoding used for pipeline bubbles, and the default reset and exception
//   vectors.
//   Optional feature macro used by the stage: IFETCH_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // A bubble carries the all-zero word, which decode treats as a NOP.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  // Byte address -> word address; the two low bits never select memory.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return {2'b00, byte_addr[ADDR_W-1:2]};
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Update priority, highest first:
//     rst   -> clear every field
//     flush -> bubble (NOP, valid = 0); id_pc / id_pc_plus4 keep their value
//     stall -> hold every field
//     else  -> capture the fetched word and its PC
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     flush, stall         pipeline control
//     fetch_instr          word returned by instruction memory
//     fetch_pc             PC the word was fetched from
//     fetch_pc_plus4       fetch_pc + 4
//     id_instr, id_pc,
//     id_pc_plus4, id_valid   registered outputs to decode
// -----------------------------------------------------------------------------
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic [ADDR_W-1:0]  fetch_pc,
  input  logic [ADDR_W-1:0]  fetch_pc_plus4,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic               id_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (flush) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr    <= fetch_instr;
      id_pc       <= fetch_pc;
      id_pc_plus4 <= fetch_pc_plus4;
      id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: owns the program counter, drives the word address to
//   instruction memory and registers the returned word into IF/ID.
//   Memory samples imem_addr on the falling edge, so imem_data is stable
//   before the next rising edge, where it is captured.
//
//   Control semantics (sampled on the rising edge): redirect_valid is a
//   one-cycle request that always wins over stall and bubbles IF/ID; stall
//   freezes pc and IF/ID for every edge it is high; flush bubbles IF/ID
//   without affecting pc. There is no back-pressure toward later stages.
//
//   Optional feature: IFETCH_MISALIGN_TRAP_EN. When defined, a redirect to a
//   non-word-aligned target loads EXC_VECTOR and pulses misalign_exc for one
//   cycle. When undefined, the target is loaded as-is and misalign_exc is 0.
//
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     stall, flush                   pipeline control
//     redirect_valid, redirect_pc    control-flow redirect request/target
//     imem_addr                      word address to memory ({2'b00, pc[31:2]})
//     imem_data                      instruction word from memory
//     pc                             current fetch PC (byte address)
//     id_instr, id_pc, id_pc_plus4, id_valid   IF/ID register outputs
//     misalign_exc                   misaligned-redirect trap pulse
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic               id_valid,
  output logic               misalign_exc
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_next;
  logic              bubble;

  // 32-bit modulo add: 32'hFFFF_FFFC wraps to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = word_addr(pc);
  // Any redirect also discards the word currently being fetched.
  assign bubble    = flush | redirect_valid;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misalign_hit;
  assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

  always_comb begin
    pc_next = pc_plus4;
    if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_next = misalign_hit ? EXC_VECTOR : redirect_pc;
`else
      pc_next = redirect_pc;
`endif
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  // Registered so the pulse occupies the cycle after the redirect edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= misalign_hit;
    end
  end
`else
  assign misalign_exc = 1'b0;
`endif

  if_id_reg u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .flush          (bubble),
    .stall          (stall),
    .fetch_instr    (imem_data),
    .fetch_pc       (pc),
    .fetch_pc_plus4 (pc_plus4),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed bench for instruction_fetch. A small memory model answers
//   imem_addr on the falling edge with 32'hA000_0000 | word_index for the
//   first 1K words and 0 beyond that.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        misalign_exc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .pc             (pc),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid),
    .misalign_exc   (misalign_exc)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd1024) return 32'hA000_0000 | a;
    return 32'h0;
  endfunction

  initial imem_data = 32'h0;
  always @(negedge clk) imem_data <= mem_word(imem_addr);

  // ---------------- driver tasks ----------------
  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", misalign_exc); end
  endtask

  task automatic test_free_run();
    logic [31:0] e;
    do_reset();
    exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      n_checks++; if (pc !== e) begin n_fail++; $display("FAIL run_pc[%0d]: got %h expected %h", i, pc, e); end
      n_checks++; if (id_pc !== e - 32'd4) begin n_fail++; $display("FAIL run_id_pc[%0d]: got %h expected %h", i, id_pc, e - 32'd4); end
      n_checks++; if (id_pc_plus4 !== e) begin n_fail++; $display("FAIL run_id_pc_plus4[%0d]: got %h expected %h", i, id_pc_plus4, e); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid[%0d]: got %b expected 1", i, id_valid); end
      n_checks++; if (id_instr !== (32'hA000_0000 | ((e - 32'd4) >> 2))) begin
        n_fail++; $display("FAIL run_instr[%0d]: got %h expected %h", i, id_instr, 32'hA000_0000 | ((e - 32'd4) >> 2));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();  // pc = 8, id_pc = 4
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, 32'h8); end
      n_checks++; if (id_pc !== 32'h4) begin n_fail++; $display("FAIL stall_id_pc[%0d]: got %h expected %h", i, id_pc, 32'h4); end
      n_checks++; if (id_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, id_instr, 32'hA000_0001); end
    end
    stall = 1'b0;
    step();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL stall_resume_pc: got %h expected %h", pc, 32'hC); end
    n_checks++; if (id_pc !== 32'h8) begin n_fail++; $display("FAIL stall_resume_id_pc: got %h expected %h", id_pc, 32'h8); end
    n_checks++; if (id_instr !== 32'hA000_0002) begin n_fail++; $display("FAIL stall_resume_instr: got %h expected %h", id_instr, 32'hA000_0002); end
  endtask

  task automatic test_redirect_over_stall();
    // Continues from test_stall: pc = 12, id_pc = 8.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %h expected %h", pc, 32'h40); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL redir_bubble_instr: got %h expected 0", id_instr); end
    n_checks++; if (id_pc !== 32'h8) begin n_fail++; $display("FAIL redir_bubble_id_pc: got %h expected %h", id_pc, 32'h8); end
    idle_inputs();
    step();
    n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL redir_next_pc: got %h expected %h", pc, 32'h44); end
    n_checks++; if (id_pc !== 32'h40) begin n_fail++; $display("FAIL redir_id_pc: got %h expected %h", id_pc, 32'h40); end
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_instr !== 32'hA000_0010) begin n_fail++; $display("FAIL redir_instr: got %h expected %h", id_instr, 32'hA000_0010); end
    n_checks++; if (id_pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL redir_pc_plus4: got %h expected %h", id_pc_plus4, 32'h44); end
  endtask

  task automatic test_flush();
    do_reset();
    step(); step(); step(); step();  // pc = 16, id_pc = 12
    flush = 1'b1;
    step();
    n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL flush_pc: got %h expected %h", pc, 32'h14); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL flush_instr: got %h expected 0", id_instr); end
    n_checks++; if (id_pc !== 32'hC) begin n_fail++; $display("FAIL flush_id_pc_hold: got %h expected %h", id_pc, 32'hC); end
    flush = 1'b0;
    step();
    n_checks++; if (id_pc !== 32'h14) begin n_fail++; $display("FAIL flush_after_id_pc: got %h expected %h", id_pc, 32'h14); end
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL flush_after_valid: got %b expected 1", id_valid); end
  endtask

  task automatic test_out_of_range();
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 32'h400) begin n_fail++; $display("FAIL oor_addr: got %h expected %h", imem_addr, 32'h400); end
    step();
    n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL oor_instr: got %h expected 0", id_instr); end
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL oor_valid: got %b expected 1", id_valid); end
    n_checks++; if (id_pc !== 32'h1000) begin n_fail++; $display("FAIL oor_id_pc: got %h expected %h", id_pc, 32'h1000); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", pc, 32'hFFFF_FFFC); end
    step();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", pc); end
    n_checks++; if (id_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_id_pc: got %h expected %h", id_pc, 32'hFFFF_FFFC); end
    n_checks++; if (id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected 0", id_pc_plus4); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    n_checks++; if (pc !== 32'h180) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc, 32'h180); end
    n_checks++; if (misalign_exc !== 1'b1) begin n_fail++; $display("FAIL mis_exc_high: got %b expected 1", misalign_exc); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL mis_bubble: got %b expected 0", id_valid); end
    step();
    n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL mis_exc_low: got %b expected 0", misalign_exc); end
    n_checks++; if (pc !== 32'h184) begin n_fail++; $display("FAIL mis_next_pc: got %h expected %h", pc, 32'h184); end
`else
    n_checks++; if (pc !== 32'h42) begin n_fail++; $display("FAIL mis_pc: got %h expected %h", pc, 32'h42); end
    n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL mis_addr: got %h expected %h", imem_addr, 32'h10); end
    n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL mis_exc: got %b expected 0", misalign_exc); end
    step();
    n_checks++; if (pc !== 32'h46) begin n_fail++; $display("FAIL mis_next_pc: got %h expected %h", pc, 32'h46); end
    n_checks++; if (id_pc !== 32'h42) begin n_fail++; $display("FAIL mis_id_pc: got %h expected %h", id_pc, 32'h42); end
    n_checks++; if (id_instr !== 32'hA000_0010) begin n_fail++; $display("FAIL mis_instr: got %h expected %h", id_instr, 32'hA000_0010); end
`endif
  endtask

  task automatic test_reset_priority();
    step(); step();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
    step();
    idle_inputs(); rst = 1'b0;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rstprio_pc: got %h expected 0", pc); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rstprio_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL rstprio_id_pc: got %h expected 0", id_pc); end
    step();
    n_checks++; if (id_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL rstprio_first_instr: got %h expected %h", id_instr, 32'hA000_0000); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_flush();
    test_out_of_range();
    test_wrap();
    test_misalign();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
